// File: rtl/kuznechik_decipher_pkg.sv
// Shared Kuznechik definitions: round/linear counts, FSM encoding, l coefficients,
// the Pi substitution and its inverse, GF(2^8) multiply, and the GOST test round keys.
package kuznechik_defs;

  localparam int ROUND_N  = 10;
  localparam int LINEAR_N = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    KEY    = 3'd1,
    LINV   = 3'd2,
    SINV   = 3'd3,
    FINISH = 3'd4
  } state_e;

  // Coefficients of l(a15, ..., a0), listed from a15 down to a0.
  localparam logic [7:0] L_COEF [LINEAR_N] = '{
    8'd148, 8'd32, 8'd133, 8'd16, 8'd194, 8'd192, 8'd1, 8'd251,
    8'd1, 8'd192, 8'd194, 8'd16, 8'd133, 8'd32, 8'd148, 8'd1
  };

  localparam int PI [256] = '{
    252, 238, 221,  17, 207, 110,  49,  22, 251, 196, 250, 218,  35, 197,   4,  77,
    233, 119, 240, 219, 147,  46, 153, 186,  23,  54, 241, 187,  20, 205,  95, 193,
    249,  24, 101,  90, 226,  92, 239,  33, 129,  28,  60,  66, 139,   1, 142,  79,
      5, 132,   2, 174, 227, 106, 143, 160,   6,  11, 237, 152, 127, 212, 211,  31,
    235,  52,  44,  81, 234, 200,  72, 171, 242,  42, 104, 162, 253,  58, 206, 204,
    181, 112,  14,  86,   8,  12, 118,  18, 191, 114,  19,  71, 156, 183,  93, 135,
     21, 161, 150,  41,  16, 123, 154, 199, 243, 145, 120, 111, 157, 158, 178, 177,
     50, 117,  25,  61, 255,  53, 138, 126, 109,  84, 198, 128, 195, 189,  13,  87,
    223, 245,  36, 169,  62, 168,  67, 201, 215, 121, 214, 246, 124,  34, 185,   3,
    224,  15, 236, 222, 122, 148, 176, 188, 220, 232,  40,  80,  78,  51,  10,  74,
    167, 151,  96, 115,  30,   0,  98,  68,  26, 184,  56, 130, 100, 159,  38,  65,
    173,  69,  70, 146,  39,  94,  85,  47, 140, 163, 165, 125, 105, 213, 149,  59,
      7,  88, 179,  64, 134, 172,  29, 247,  48,  55, 107, 228, 136, 217, 231, 137,
    225,  27, 131,  73,  76,  63, 248, 254, 141,  83, 170, 144, 202, 216, 133,  97,
     32, 113, 103, 164,  45,  43,   9,  91, 203, 155,  37, 208, 190, 229, 108,  82,
     89, 166, 116, 210, 230, 244, 180, 192, 209, 102, 175, 194,  57,  75,  99, 182
  };

  // Multiply in GF(2^8) modulo x^8 + x^7 + x^6 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'hC3) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [2047:0] build_pi_inv();
    logic [2047:0] t;
    t = '0;
    for (int i = 0; i < 256; i++) t[PI[i]*8 +: 8] = 8'(i);
    return t;
  endfunction

  // Inverse S-box packed so that entry v sits at bits [8v+7:8v].
  localparam logic [2047:0] PI_INV_FLAT = build_pi_inv();

  function automatic logic [7:0] sbox_inv(input logic [7:0] b);
    return PI_INV_FLAT[{b, 3'b000} +: 8];
  endfunction

  // Round keys of the GOST R 34.12-2015 example; element i holds K(i+1).
  localparam logic [ROUND_N-1:0][127:0] GOST_TEST_KEYS = {
    128'h72e9dd7416bcf45b755dbaa88e4a4043,
    128'hbb44e25378c73123a5f32f73cdb6e517,
    128'h5a7925017b9fdd3ed72a91a22286f984,
    128'h51e640757e8745de705727265a0098b1,
    128'hbd079435165c6432b532e82834da581b,
    128'h57646468c44a5e28d3e59246f429f1ac,
    128'h3d4553d8e9cfec6815ebadc40a9ffd04,
    128'hdb31485315694343228d6aef8cc78c44,
    128'hfedcba98765432100123456789abcdef,
    128'h8899aabbccddeeff0011223344556677
  };

endpackage

// File: rtl/kuznechik_decipher_if.sv
// Request/busy/valid/ack block bus shared by the Kuznechik encryptor and decryptor.
interface kuznechik_decipher_if;

    logic         request_i;
    logic         ack_i;
    logic [127:0] data_i;
    logic         busy_o;
    logic         valid_o;
    logic [127:0] data_o;

    modport master (
        output request_i, ack_i, data_i,
        input  busy_o, valid_o, data_o
    );

    modport slave (
        input  request_i, ack_i, data_i,
        output busy_o, valid_o, data_o
    );

endinterface

// File: rtl/kuznechik_decipher_r_inv.sv
// One combinational R^-1 step: shift bytes up and append l(b14..b0, b15) as the new b0.
module kuznechik_r_inv
    import kuznechik_defs::*;
(
    input  logic [127:0] data_i,
    output logic [127:0] data_o
);

    function automatic logic [2047:0] mul_table(input logic [7:0] coef);
        logic [2047:0] t;
        t = '0;
        for (int i = 0; i < 256; i++) t[i*8 +: 8] = gf_mul(coef, 8'(i));
        return t;
    endfunction

    localparam logic [2047:0] T16  = mul_table(8'd16);
    localparam logic [2047:0] T32  = mul_table(8'd32);
    localparam logic [2047:0] T133 = mul_table(8'd133);
    localparam logic [2047:0] T148 = mul_table(8'd148);
    localparam logic [2047:0] T192 = mul_table(8'd192);
    localparam logic [2047:0] T194 = mul_table(8'd194);
    localparam logic [2047:0] T251 = mul_table(8'd251);

    function automatic logic [7:0] mul_by(input logic [7:0] coef, input logic [7:0] b);
        logic [10:0] idx;
        idx = {b, 3'b000};
        case (coef)
            8'd16:   mul_by = T16[idx +: 8];
            8'd32:   mul_by = T32[idx +: 8];
            8'd133:  mul_by = T133[idx +: 8];
            8'd148:  mul_by = T148[idx +: 8];
            8'd192:  mul_by = T192[idx +: 8];
            8'd194:  mul_by = T194[idx +: 8];
            8'd251:  mul_by = T251[idx +: 8];
            default: mul_by = b;
        endcase
    endfunction

    logic [127:0] args;
    logic [7:0]   l_sum;

    // args holds a15..a0 = b14..b0, b15 so coefficient k pairs with args byte 15-k.
    assign args = {data_i[119:0], data_i[127:120]};

    always_comb begin
        l_sum = '0;
        for (int k = 0; k < LINEAR_N; k++) begin
            l_sum = l_sum ^ mul_by(L_COEF[k], args[(LINEAR_N-1-k)*8 +: 8]);
        end
    end

    assign data_o = {data_i[119:0], l_sum};

endmodule

// File: rtl/kuznechik_decipher.sv
// Iterative Kuznechik block decryptor: X[K10], then nine rounds of L^-1, S^-1, X[Kr].
module kuznechik_decipher
    import kuznechik_defs::*;
#(
    parameter logic [ROUND_N-1:0][127:0] ROUND_KEYS = GOST_TEST_KEYS
) (
    input  logic                 clk_i,
    input  logic                 resetn_i,
    kuznechik_decipher_if.slave  bus
);

    state_e       state_q, state_d;
    logic [127:0] blk_q, blk_d;
    logic [127:0] out_q, out_d;
    logic         valid_q, valid_d;
    logic [3:0]   round_idx_q, round_idx_d;
    logic [3:0]   lin_cnt_q, lin_cnt_d;

    logic [127:0] r_inv_out;
    logic [127:0] s_inv_out;
    logic [127:0] key_xor;

    kuznechik_r_inv u_r_inv (
        .data_i (blk_q),
        .data_o (r_inv_out)
    );

    always_comb begin
        s_inv_out = '0;
        for (int i = 0; i < 16; i++) s_inv_out[i*8 +: 8] = sbox_inv(blk_q[i*8 +: 8]);
    end

    assign key_xor = blk_q ^ ROUND_KEYS[round_idx_q];

    always_comb begin
        // NOTE: every _d gets its hold value first so no path through the case can infer a latch.
        state_d     = state_q;
        blk_d       = blk_q;
        out_d       = out_q;
        valid_d     = valid_q;
        round_idx_d = round_idx_q;
        lin_cnt_d   = lin_cnt_q;

        case (state_q)
            IDLE: begin
                if (bus.request_i) begin
                    blk_d       = bus.data_i;
                    round_idx_d = 4'(ROUND_N - 1);
                    state_d     = KEY;
                end
            end
            KEY: begin
                blk_d = key_xor;
                if (round_idx_q == 4'd0) begin
                    out_d   = key_xor;
                    valid_d = 1'b1;
                    state_d = FINISH;
                end else begin
                    round_idx_d = round_idx_q - 4'd1;
                    lin_cnt_d   = 4'd0;
                    state_d     = LINV;
                end
            end
            LINV: begin
                blk_d     = r_inv_out;
                lin_cnt_d = lin_cnt_q + 4'd1;
                if (lin_cnt_q == 4'(LINEAR_N - 1)) state_d = SINV;
            end
            SINV: begin
                blk_d   = s_inv_out;
                state_d = KEY;
            end
            FINISH: begin
                // A request arriving with the ack is dropped; IDLE takes the next one.
                if (bus.ack_i) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q     <= IDLE;
            blk_q       <= '0;
            out_q       <= '0;
            valid_q     <= 1'b0;
            round_idx_q <= '0;
            lin_cnt_q   <= '0;
        end else begin
            // NOTE: registers update with <= so every flop samples the pre-edge values together.
            state_q     <= state_d;
            blk_q       <= blk_d;
            out_q       <= out_d;
            valid_q     <= valid_d;
            round_idx_q <= round_idx_d;
            lin_cnt_q   <= lin_cnt_d;
        end
    end

    assign bus.busy_o  = (state_q != IDLE);
    assign bus.valid_o = valid_q;
    assign bus.data_o  = out_q;

endmodule

// File: tb/tb_kuznechik_decipher.sv
// Directed bench for kuznechik_decipher: known vector, unit steps, handshake corners, reset, round trip.
module tb_kuznechik_decipher;
    import kuznechik_defs::*;

    localparam logic [127:0] CT = 128'h7f679d90bebc24305a468d42b9d4edcd;
    localparam logic [127:0] PT = 128'h1122334455667700ffeeddccbbaa9988;
    localparam int           LAT = 163;

    logic clk_i = 1'b0;
    logic resetn_i;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk_i = ~clk_i;

    kuznechik_decipher_if bus ();

    kuznechik_decipher dut (
        .clk_i    (clk_i),
        .resetn_i (resetn_i),
        .bus      (bus)
    );

    logic [127:0]        unit_in;
    logic [16:0][127:0]  chain;
    assign chain[0] = unit_in;
    for (genvar g = 0; g < 16; g++) begin : g_chain
        kuznechik_r_inv u_step (.data_i(chain[g]), .data_o(chain[g+1]));
    end

    // Forward cipher used only to produce round-trip ciphertexts.
    function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = '0;
        for (int i = 7; i >= 0; i--) begin
            p = p[7] ? ((p << 1) ^ 8'hC3) : (p << 1);
            if (b[i]) p = p ^ a;
        end
        return p;
    endfunction

    function automatic logic [127:0] tb_encrypt(input logic [127:0] p);
        logic [127:0] s;
        logic [7:0]   acc;
        s = p;
        for (int r = 0; r < 9; r++) begin
            s = s ^ GOST_TEST_KEYS[r];
            for (int i = 0; i < 16; i++) s[i*8 +: 8] = 8'(PI[s[i*8 +: 8]]);
            for (int n = 0; n < 16; n++) begin
                acc = '0;
                for (int k = 0; k < 16; k++) acc = acc ^ tb_mul(L_COEF[k], s[(15-k)*8 +: 8]);
                s = {acc, s[127:8]};
            end
        end
        return s ^ GOST_TEST_KEYS[9];
    endfunction

    task automatic start_block(input logic [127:0] ct);
        bus.data_i    = ct;
        bus.request_i = 1'b1;
        @(posedge clk_i); #1;
        bus.request_i = 1'b0;
    endtask

    task automatic wait_valid(input int start, output int lat);
        lat = -1;
        for (int n = start + 1; n <= start + 400; n++) begin
            @(posedge clk_i); #1;
            if (bus.valid_o === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic ack_block();
        bus.ack_i = 1'b1;
        @(posedge clk_i); #1;
        bus.ack_i = 1'b0;
    endtask

    task automatic test_reset();
        resetn_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        n_cmp++; if (bus.busy_o !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.busy_o); end
        n_cmp++; if (bus.valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", bus.valid_o); end
        n_cmp++; if (bus.data_o !== 128'h0) begin n_bad++; $display("FAIL reset_data: got %h want 0", bus.data_o); end
        @(negedge clk_i) resetn_i = 1'b1;
        @(posedge clk_i); #1;
    endtask

    task automatic test_units();
        unit_in = 128'hd456584dd0e3e84cc3166e4b7fa2890d;
        #1;
        n_cmp++; if (chain[16] !== 128'h64a59400000000000000000000000000) begin
            n_bad++; $display("FAIL linv_unit: got %h want 64a59400000000000000000000000000", chain[16]);
        end
        unit_in = 128'hb66cd8887d38e8d77765aeea0c9a7efc;
        for (int i = 0; i < 16; i++) unit_in[i*8 +: 8] = sbox_inv(unit_in[i*8 +: 8]);
        n_cmp++; if (unit_in !== 128'hffeeddccbbaa99881122334455667700) begin
            n_bad++; $display("FAIL sinv_unit: got %h want ffeeddccbbaa99881122334455667700", unit_in);
        end
    endtask

    task automatic test_known_vector();
        int lat;
        start_block(CT);
        n_cmp++; if (bus.busy_o !== 1'b1) begin n_bad++; $display("FAIL kv_busy_rise: got %b want 1", bus.busy_o); end
        wait_valid(0, lat);
        n_cmp++; if (lat != LAT) begin n_bad++; $display("FAIL kv_latency: got %0d want %0d", lat, LAT); end
        n_cmp++; if (bus.data_o !== PT) begin n_bad++; $display("FAIL kv_data: got %h want %h", bus.data_o, PT); end
        ack_block();
        n_cmp++; if (bus.valid_o !== 1'b0) begin n_bad++; $display("FAIL kv_valid_fall: got %b want 0", bus.valid_o); end
        n_cmp++; if (bus.busy_o !== 1'b0) begin n_bad++; $display("FAIL kv_busy_fall: got %b want 0", bus.busy_o); end
        n_cmp++; if (bus.data_o !== PT) begin n_bad++; $display("FAIL kv_data_kept: got %h want %h", bus.data_o, PT); end
    endtask

    task automatic test_request_while_busy();
        int lat;
        logic seen_valid;
        logic seen_busy;
        start_block(CT);
        repeat (48) @(posedge clk_i);
        #1;
        bus.data_i    = 128'h0123456789abcdef0123456789abcdef;
        bus.request_i = 1'b1;
        @(posedge clk_i); #1;
        bus.request_i = 1'b0;
        wait_valid(49, lat);
        n_cmp++; if (lat != LAT) begin n_bad++; $display("FAIL busy_req_latency: got %0d want %0d", lat, LAT); end
        n_cmp++; if (bus.data_o !== PT) begin n_bad++; $display("FAIL busy_req_data: got %h want %h", bus.data_o, PT); end
        ack_block();
        seen_valid = 1'b0;
        seen_busy  = 1'b0;
        repeat (200) begin
            @(posedge clk_i); #1;
            seen_valid = seen_valid | bus.valid_o;
            seen_busy  = seen_busy | bus.busy_o;
        end
        n_cmp++; if (seen_valid !== 1'b0) begin n_bad++; $display("FAIL busy_req_second_valid: got %b want 0", seen_valid); end
        n_cmp++; if (seen_busy !== 1'b0) begin n_bad++; $display("FAIL busy_req_second_busy: got %b want 0", seen_busy); end
    endtask

    task automatic test_hold_and_ack_request();
        int lat;
        start_block(CT);
        wait_valid(0, lat);
        n_cmp++; if (lat != LAT) begin n_bad++; $display("FAIL hold_latency: got %0d want %0d", lat, LAT); end
        for (int c = 0; c < 20; c++) begin
            @(posedge clk_i); #1;
            n_cmp++;
            if (bus.valid_o !== 1'b1 || bus.data_o !== PT) begin
                n_bad++; $display("FAIL hold_stable c=%0d: got valid=%b data=%h want valid=1 data=%h", c, bus.valid_o, bus.data_o, PT);
            end
        end
        bus.data_i    = CT;
        bus.request_i = 1'b1;
        bus.ack_i     = 1'b1;
        @(posedge clk_i); #1;
        bus.ack_i = 1'b0;
        n_cmp++; if (bus.busy_o !== 1'b0) begin n_bad++; $display("FAIL ackreq_idle: got busy=%b want 0", bus.busy_o); end
        n_cmp++; if (bus.valid_o !== 1'b0) begin n_bad++; $display("FAIL ackreq_valid: got %b want 0", bus.valid_o); end
        @(posedge clk_i); #1;
        bus.request_i = 1'b0;
        n_cmp++; if (bus.busy_o !== 1'b1) begin n_bad++; $display("FAIL ackreq_next_accept: got busy=%b want 1", bus.busy_o); end
        wait_valid(0, lat);
        n_cmp++; if (lat != LAT) begin n_bad++; $display("FAIL ackreq_latency: got %0d want %0d", lat, LAT); end
        n_cmp++; if (bus.data_o !== PT) begin n_bad++; $display("FAIL ackreq_data: got %h want %h", bus.data_o, PT); end
        ack_block();
    endtask

    task automatic test_back_to_back();
        int lat;
        bus.data_i    = CT;
        bus.request_i = 1'b1;
        @(posedge clk_i); #1;
        wait_valid(0, lat);
        n_cmp++; if (lat != LAT) begin n_bad++; $display("FAIL b2b_first_latency: got %0d want %0d", lat, LAT); end
        ack_block();
        wait_valid(1, lat);
        n_cmp++; if (lat != 165) begin n_bad++; $display("FAIL b2b_period: got %0d want 165", lat); end
        n_cmp++; if (bus.data_o !== PT) begin n_bad++; $display("FAIL b2b_data: got %h want %h", bus.data_o, PT); end
        bus.request_i = 1'b0;
        ack_block();
    endtask

    task automatic test_reset_mid();
        int lat;
        start_block(CT);
        repeat (79) @(posedge clk_i);
        #2;
        resetn_i = 1'b0;
        #1;
        n_cmp++; if (bus.busy_o !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b want 0", bus.busy_o); end
        n_cmp++; if (bus.valid_o !== 1'b0) begin n_bad++; $display("FAIL midrst_valid: got %b want 0", bus.valid_o); end
        n_cmp++; if (bus.data_o !== 128'h0) begin n_bad++; $display("FAIL midrst_data: got %h want 0", bus.data_o); end
        @(negedge clk_i) resetn_i = 1'b1;
        @(posedge clk_i); #1;
        start_block(CT);
        wait_valid(0, lat);
        n_cmp++; if (lat != LAT) begin n_bad++; $display("FAIL midrst_latency: got %0d want %0d", lat, LAT); end
        n_cmp++; if (bus.data_o !== PT) begin n_bad++; $display("FAIL midrst_data_after: got %h want %h", bus.data_o, PT); end
        ack_block();
    endtask

    task automatic test_round_trip();
        int lat;
        logic [127:0] pt;
        for (int b = 0; b < 8; b++) begin
            pt = {$urandom(), $urandom(), $urandom(), $urandom()};
            start_block(tb_encrypt(pt));
            wait_valid(0, lat);
            n_cmp++;
            if (lat != LAT || bus.data_o !== pt) begin
                n_bad++; $display("FAIL round_trip b=%0d: got lat=%0d data=%h want lat=%0d data=%h", b, lat, bus.data_o, LAT, pt);
            end
            ack_block();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.request_i = 1'b0;
        bus.ack_i     = 1'b0;
        bus.data_i    = '0;
        unit_in       = '0;
        test_reset();
        test_units();
        test_known_vector();
        test_request_while_busy();
        test_hold_and_ack_request();
        test_back_to_back();
        test_reset_mid();
        test_round_trip();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/kuznechik_decipher.md
# kuznechik_decipher

Iterative GOST R 34.12-2015 (Kuznechik) block decryptor; the inverse partner of the team's Kuznechik encryptor, sharing its round-key and multiplier memory images. It accepts one 128-bit ciphertext block per request, runs the 10 inverse rounds (X, L⁻¹, S⁻¹) over ~163 cycles, and holds the plaintext until the consumer acknowledges. It sits on the same request/busy/valid/ack bus as the encryptor, so the two are interchangeable to a host.

## Interface
- KEY_FILE, "keys.mem": 10 × 128-bit round keys K1..K10, stored in key_mem[0..9].
- SBOX_INV_FILE, "S_box_inv.mem": 256 × 8-bit inverse S-box.
- clk_i  in  1  clock, single domain.
- resetn_i  in  1  reset; asynchronous assertion, active low.
- request_i  in  1  start request; sampled only in IDLE.
- ack_i  in  1  consumer has taken data_o; sampled only in FINISH.
- data_i  in  128  ciphertext; captured on the accepted request edge.
- busy_o  out  1  high whenever state ≠ IDLE.
- valid_o  out  1  plaintext on data_o is valid (registered).
- data_o  out  128  plaintext (registered).

## Operation
- Byte convention: b15 = bits[127:120] … b0 = bits[7:0], identical to the encryptor.
- Algorithm: s = C ⊕ K10; for r = 9 down to 1: s = L⁻¹(s); s = S⁻¹(s); s = s ⊕ Kr; P = s.
- L⁻¹ is 16 iterations of R⁻¹: R⁻¹(b15..b0) = (b14..b0, l(b14,…,b0,b15)).
  - l coefficients in argument order: 148, 32, 133, 16, 194, 192, 1, 251, 1, 192, 194, 16, 133, 32, 148, 1.
  - Multiplications use the shared L_16/32/133/148/192/194/251 tables. Sums are XOR.
- S⁻¹ is a byte-wise lookup in the inverse S-box, all 16 bytes in one cycle.
- FSM states (3-bit): IDLE, KEY, LINV, SINV, FINISH.
  - IDLE: on request_i, capture data_i into the state register, set round_idx = 9, go to KEY.
  - KEY: state ^= key_mem[round_idx].
    - If round_idx == 0: data_o <= result, valid_o <= 1, go to FINISH.
    - Otherwise: round_idx -= 1, lin_cnt = 0, go to LINV.
  - LINV: state <= R⁻¹(state), lin_cnt += 1. On lin_cnt == 15, go to SINV.
  - SINV: state <= S⁻¹(state), go to KEY.
  - FINISH: hold data_o and valid_o. On ack_i: valid_o <= 0, go to IDLE.
- Counters: round_idx is 4-bit and counts down 9→0. lin_cnt is 4-bit and wraps 15→0 naturally.
- All next-state and datapath logic is fully registered; no latches. Combinational blocks use blocking assignment only.

## Timing
- Reset (async, resetn_i = 0): state = IDLE, busy_o = 0, valid_o = 0, data_o = 0, round_idx = 0, lin_cnt = 0, state register = 0.
- Reset asserted mid-operation aborts the block immediately: no valid_o, and no partial data on data_o.
- Latency: request accepted at edge E0; valid_o rises at edge E0 + 163 (1 + 9 × (16 + 1 + 1)).
- busy_o rises the cycle after the accepted request and falls the cycle after ack_i is seen in FINISH.
- request_i while busy_o = 1 is ignored; it is not queued.
- ack_i outside FINISH is ignored.
- ack_i and request_i together in FINISH: the ack is consumed and the request is ignored. The next request is accepted from IDLE, one cycle later at the earliest.
- data_o keeps the last plaintext after ack, until the next FINISH overwrites it.
- Back-to-back throughput: one block per 165 cycles, given a request held high and an ack on the first valid cycle.

## Structure
- Shared package/include `kuznechik_defs`: ROUND_N = 10, LINEAR_N = 16, the FSM state encodings, and the l coefficient list. The encryptor uses the same package.
- Sub-module `kuznechik_r_inv`: combinational single R⁻¹ step (128 in → 128 out). It owns the seven multiplier tables and the XOR tree.
- The top level holds the FSM, counters, key memory, inverse S-box, and output registers.

## Test plan
- Decrypt 7f679d90bebc24305a468d42b9d4edcd with the standard GOST round keys → data_o = 1122334455667700ffeeddccbbaa9988, valid_o high exactly 163 cycles after acceptance.
- L⁻¹ unit check (kuznechik_r_inv ×16): d456584dd0e3e84cc3166e4b7fa2890d → 64a59400000000000000000000000000. S⁻¹ check: b66cd8887d38e8d77765aeea0c9a7efc → ffeeddccbbaa99881122334455667700.
- Request pulse while busy (cycle 50) → ignored; the first result is unchanged and only one valid_o episode occurs.
- Hold ack_i low for 20 cycles after valid → valid_o and data_o stable throughout. Assert ack_i together with request_i → IDLE, then the next request is accepted one cycle later.
- Assert resetn_i = 0 at cycle 80 of a decryption → busy_o = 0, valid_o = 0, data_o = 0 immediately. A fresh request afterwards decrypts correctly.
- Round-trip: 8 random blocks through the encryptor, then this block → original plaintext each time.
